// File: rtl/bus_pkg.sv
// Shared bus definitions: response codes, slave ids and the layout of a captured transfer record.
package bus_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY  = 2'b00,
        RESP_ERROR = 2'b01,
        RESP_RETRY = 2'b10,
        RESP_SPLIT = 2'b11
    } resp_e;

    localparam logic [1:0] SLV_1 = 2'b01;
    localparam logic [1:0] SLV_2 = 2'b10;
    localparam logic [1:0] SLV_3 = 2'b11;

    // Record layout, MSB first: {lock, master, slave, write, resp, addr[11:0], data[31:0]}
    localparam int REC_W     = 52;
    localparam int DATA_LSB  = 0;
    localparam int ADDR_LSB  = 32;
    localparam int RESP_LSB  = 44;
    localparam int WRITE_BIT = 46;
    localparam int SLV_LSB   = 47;
    localparam int MAS_LSB   = 49;
    localparam int LOCK_BIT  = 51;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; the head entry is visible whenever the FIFO is not empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_rd;
    logic             do_wr;

    // The extra wrap bit distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    // Head is forced to zero when empty so stale entries never leak out after reset.
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/bus_txn_monitor.sv
// Passive bus observer: records completed transfers, counts responses per slave and
// flags stalls, multi-select and dropped records.
module bus_txn_monitor
    import bus_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [15:0]      HADDR,
    input  logic [31:0]      HWDATA,
    input  logic [31:0]      HRDATA,
    input  logic [1:0]       HRESP,
    input  logic             HREADY,
    input  logic [1:0]       HMAS,
    input  logic             HWRITE,
    input  logic             SEL_1,
    input  logic             SEL_2,
    input  logic             SEL_3,
    input  logic             MLOCK,
    input  logic             EN,
    input  logic             CLR,
    input  logic             REC_POP,
    output logic             REC_VALID,
    output logic [REC_W-1:0] REC_DATA,
    output logic [CNT_W-1:0] CNT_S1,
    output logic [CNT_W-1:0] CNT_S2,
    output logic [CNT_W-1:0] CNT_S3,
    output logic [CNT_W-1:0] CNT_ERR,
    output logic [CNT_W-1:0] CNT_SPLIT,
    output logic             OVF,
    output logic             STALL,
    output logic             SEL_FAULT
);
    localparam int                WCNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(TIMEOUT);

    logic [2:0]        sel_vec;
    logic              any_sel, one_sel, multi_sel, beat, waiting;
    logic              push, pop, drop;
    logic              fifo_full, fifo_empty;
    logic [1:0]        slave;
    logic [REC_W-1:0]  rec;
    logic [WCNT_W-1:0] wcnt, wcnt_next;
    logic [3:0]        unused_addr_hi;

    assign unused_addr_hi = HADDR[15:12];

    assign sel_vec   = {SEL_3, SEL_2, SEL_1};
    assign any_sel   = |sel_vec;
    assign one_sel   = (sel_vec == 3'b001) || (sel_vec == 3'b010) || (sel_vec == 3'b100);
    assign multi_sel = any_sel && !one_sel;
    assign beat      = HREADY && one_sel;
    assign waiting   = any_sel && !HREADY;
    assign push      = beat && EN;
    assign pop       = REC_POP && !fifo_empty;
    assign drop      = push && fifo_full && !pop;

    always_comb begin
        slave = 2'b00;
        if (SEL_1)      slave = SLV_1;
        else if (SEL_2) slave = SLV_2;
        else if (SEL_3) slave = SLV_3;
    end

    always_comb begin
        rec                     = '0;
        rec[LOCK_BIT]           = MLOCK;
        rec[MAS_LSB +: 2]       = HMAS;
        rec[SLV_LSB +: 2]       = slave;
        rec[WRITE_BIT]          = HWRITE;
        rec[RESP_LSB +: 2]      = HRESP;
        rec[ADDR_LSB +: 12]     = HADDR[11:0];
        rec[DATA_LSB +: 32]     = HWRITE ? HWDATA : HRDATA;
    end

    sync_fifo #(
        .WIDTH(REC_W),
        .DEPTH(DEPTH)
    ) u_rec_fifo (
        .clk    (CLK),
        .rst    (RST),
        .wr_en  (push),
        .rd_en  (REC_POP),
        .wr_data(rec),
        .rd_data(REC_DATA),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign REC_VALID = !fifo_empty;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // Counters advance on every beat, capture-enabled or not; CLR overrides a same-cycle event.
    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            CNT_S1    <= '0;
            CNT_S2    <= '0;
            CNT_S3    <= '0;
            CNT_ERR   <= '0;
            CNT_SPLIT <= '0;
        end else if (beat) begin
            unique case (resp_e'(HRESP))
                RESP_OKAY: begin
                    if (SEL_1) CNT_S1 <= sat_inc(CNT_S1);
                    if (SEL_2) CNT_S2 <= sat_inc(CNT_S2);
                    if (SEL_3) CNT_S3 <= sat_inc(CNT_S3);
                end
                RESP_ERROR:             CNT_ERR   <= sat_inc(CNT_ERR);
                RESP_RETRY, RESP_SPLIT: CNT_SPLIT <= sat_inc(CNT_SPLIT);
                default: ;
            endcase
        end
    end

    always_comb begin
        wcnt_next = '0;
        if (waiting) wcnt_next = (wcnt == WCNT_MAX) ? wcnt : wcnt + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) wcnt <= '0;
        else     wcnt <= wcnt_next;
    end

    // Sticky flags; STALL sets on the edge where the wait count reaches the limit.
    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            OVF       <= 1'b0;
            STALL     <= 1'b0;
            SEL_FAULT <= 1'b0;
        end else begin
            if (drop)                                OVF       <= 1'b1;
            if (multi_sel)                           SEL_FAULT <= 1'b1;
            if (waiting && (wcnt_next == WCNT_MAX))  STALL     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bus_txn_monitor.sv
// Directed bench for bus_txn_monitor: stimulus pushes expected records into a queue and an
// independent negedge monitor pops and compares them as the consumer drains the FIFO.
module tb_bus_txn_monitor;

    localparam int DEPTH   = 8;
    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 16;

    logic             CLK = 1'b0;
    logic             RST;
    logic [15:0]      HADDR;
    logic [31:0]      HWDATA, HRDATA;
    logic [1:0]       HRESP, HMAS;
    logic             HREADY, HWRITE, SEL_1, SEL_2, SEL_3, MLOCK, EN, CLR, REC_POP;
    logic             REC_VALID;
    logic [51:0]      REC_DATA;
    logic [CNT_W-1:0] CNT_S1, CNT_S2, CNT_S3, CNT_ERR, CNT_SPLIT;
    logic             OVF, STALL, SEL_FAULT;

    int          checks   = 0;
    int          failures = 0;
    logic [51:0] exp_q[$];
    bit          mon_en   = 1'b0;

    always #5 CLK = ~CLK;

    bus_txn_monitor #(
        .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(CLK), .RST(RST), .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HRESP(HRESP), .HREADY(HREADY), .HMAS(HMAS), .HWRITE(HWRITE),
        .SEL_1(SEL_1), .SEL_2(SEL_2), .SEL_3(SEL_3), .MLOCK(MLOCK), .EN(EN),
        .CLR(CLR), .REC_POP(REC_POP), .REC_VALID(REC_VALID), .REC_DATA(REC_DATA),
        .CNT_S1(CNT_S1), .CNT_S2(CNT_S2), .CNT_S3(CNT_S3), .CNT_ERR(CNT_ERR),
        .CNT_SPLIT(CNT_SPLIT), .OVF(OVF), .STALL(STALL), .SEL_FAULT(SEL_FAULT)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one cycle of bus inputs (called just after a rising edge), then records the
    // expected FIFO entry if that edge was a captured beat with room in the FIFO.
    task automatic applyStimulus(input logic [2:0] sel, input logic ready, input logic wr,
                                 input logic [1:0] mas, input logic [15:0] addr,
                                 input logic [31:0] data, input logic [1:0] resp,
                                 input logic lock, input logic en, input logic clr,
                                 input logic pop);
        logic [1:0] slv;
        {SEL_3, SEL_2, SEL_1} = sel;
        HREADY  = ready;
        HWRITE  = wr;
        HMAS    = mas;
        HADDR   = addr;
        HWDATA  = wr ? data : ~data;
        HRDATA  = wr ? ~data : data;
        HRESP   = resp;
        MLOCK   = lock;
        EN      = en;
        CLR     = clr;
        REC_POP = pop;
        @(posedge CLK);
        if (!RST && ready && en && $countones(sel) == 1) begin
            slv = sel[0] ? 2'b01 : (sel[1] ? 2'b10 : 2'b11);
            if (exp_q.size() < DEPTH)
                exp_q.push_back({lock, mas, slv, wr, resp, addr[11:0], data});
        end
        #1;
    endtask

    task automatic idle(input int n, input logic pop, input logic clr);
        for (int k = 0; k < n; k++)
            applyStimulus(3'b000, 1'b1, 1'b0, 2'b00, 16'h0, 32'h0, 2'b00, 1'b0, 1'b0, clr, pop);
    endtask

    // Scoreboard monitor: occupancy must match the queue, and every pop returns the oldest entry.
    always @(negedge CLK) begin
        if (mon_en) begin
            checkOutput("rec_valid", REC_VALID, exp_q.size() != 0);
            if (REC_POP && exp_q.size() != 0)
                checkOutput("rec_data", REC_DATA, exp_q.pop_front());
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL timeout: got still running, expected finished");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        RST = 1'b1;
        {SEL_3, SEL_2, SEL_1} = 3'b000;
        {HREADY, HWRITE, MLOCK, EN, CLR, REC_POP} = '0;
        HADDR = '0; HWDATA = '0; HRDATA = '0; HRESP = '0; HMAS = '0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        checkOutput("reset_valid", REC_VALID, 1'b0);
        checkOutput("reset_data", REC_DATA, 52'h0);
        checkOutput("reset_s1", CNT_S1, 4'd0);
        checkOutput("reset_flags", {OVF, STALL, SEL_FAULT}, 3'b000);
        mon_en = 1'b1;

        // Write beat to slave 2, then read with ERROR to slave 3
        applyStimulus(3'b010, 1, 1, 2'b01, 16'h0ABC, 32'hDEADBEEF, 2'b00, 0, 1, 0, 0);
        checkOutput("write_valid", REC_VALID, 1'b1);
        checkOutput("write_record", REC_DATA, 52'h34ABC_DEADBEEF);
        checkOutput("write_cnt_s2", CNT_S2, 4'd1);
        applyStimulus(3'b100, 1, 0, 2'b10, 16'h0123, 32'h12345678, 2'b01, 0, 1, 0, 0);
        checkOutput("err_cnt_err", CNT_ERR, 4'd1);
        checkOutput("err_cnt_s3", CNT_S3, 4'd0);
        // SPLIT and RETRY beats, upper address bits discarded, locked transfer
        applyStimulus(3'b001, 1, 1, 2'b11, 16'hFF55, 32'hCAFE0001, 2'b11, 1, 1, 0, 0);
        applyStimulus(3'b001, 1, 0, 2'b00, 16'h0010, 32'h00000042, 2'b10, 0, 1, 0, 0);
        checkOutput("split_cnt", CNT_SPLIT, 4'd2);
        checkOutput("split_cnt_s1", CNT_S1, 4'd0);
        idle(4, 1, 0);
        checkOutput("drain_valid", REC_VALID, 1'b0);

        // Push and pop together while holding one entry
        applyStimulus(3'b001, 1, 1, 2'b00, 16'h0200, 32'hA5A5A5A5, 2'b00, 0, 1, 0, 0);
        applyStimulus(3'b001, 1, 1, 2'b01, 16'h0204, 32'h5A5A5A5A, 2'b00, 0, 1, 0, 1);
        checkOutput("pushpop1_valid", REC_VALID, 1'b1);
        idle(1, 1, 1);
        checkOutput("clr_s1", CNT_S1, 4'd0);

        // Overflow: nine beats without popping; the ninth is dropped
        for (int i = 1; i <= 9; i++)
            applyStimulus(3'b001, 1, 1, 2'b00, 16'(i * 4), 32'(i), 2'b00, 0, 1, 0, 0);
        checkOutput("ovf_set", OVF, 1'b1);
        checkOutput("ovf_cnt_s1", CNT_S1, 4'd9);
        idle(8, 1, 0);
        checkOutput("ovf_drained", REC_VALID, 1'b0);
        idle(1, 0, 1);
        checkOutput("ovf_clr", OVF, 1'b0);

        // Full FIFO with a simultaneous pop on the ninth push: nothing dropped
        for (int i = 1; i <= 9; i++)
            applyStimulus(3'b001, 1, 0, 2'b10, 16'(i * 8), 32'(i + 100), 2'b00, 0, 1, 0, i == 9);
        checkOutput("fullpop_ovf", OVF, 1'b0);
        checkOutput("fullpop_valid", REC_VALID, 1'b1);
        idle(8, 1, 0);

        // Stall watchdog: 15 wait cycles are tolerated, the 16th trips it
        for (int i = 0; i < 15; i++)
            applyStimulus(3'b001, 0, 0, 2'b00, 16'h0300, 32'h0, 2'b00, 0, 0, 0, 0);
        checkOutput("stall_15", STALL, 1'b0);
        applyStimulus(3'b001, 0, 0, 2'b00, 16'h0300, 32'h0, 2'b00, 0, 0, 0, 0);
        checkOutput("stall_16", STALL, 1'b1);
        applyStimulus(3'b001, 1, 0, 2'b00, 16'h0300, 32'h0, 2'b00, 0, 0, 0, 0);
        checkOutput("stall_sticky", STALL, 1'b1);
        idle(1, 0, 1);
        checkOutput("stall_clr", STALL, 1'b0);

        // Saturation at 15, then CLR alongside an 18th beat
        for (int i = 0; i < 17; i++)
            applyStimulus(3'b001, 1, 1, 2'b00, 16'h0400, 32'(i), 2'b00, 0, 0, 0, 0);
        checkOutput("sat_s1", CNT_S1, 4'd15);
        applyStimulus(3'b001, 1, 1, 2'b00, 16'h0404, 32'h00000018, 2'b00, 0, 1, 1, 0);
        checkOutput("sat_clr_s1", CNT_S1, 4'd0);
        checkOutput("sat_clr_push", REC_VALID, 1'b1);
        idle(1, 1, 0);

        // Multi-select: fault flag, no record, no count
        applyStimulus(3'b101, 1, 1, 2'b00, 16'h0500, 32'h77777777, 2'b00, 0, 1, 0, 0);
        checkOutput("fault_flag", SEL_FAULT, 1'b1);
        checkOutput("fault_nopush", REC_VALID, 1'b0);
        checkOutput("fault_counts", {CNT_S1, CNT_S3}, 8'h00);

        // Reset with three queued records and a beat on the reset edge
        for (int i = 0; i < 3; i++)
            applyStimulus(3'b010, 1, 1, 2'b01, 16'(16'h0600 + i), 32'(i + 7), 2'b00, 0, 1, 0, 0);
        checkOutput("prereset_s2", CNT_S2, 4'd3);
        RST = 1'b1;
        applyStimulus(3'b010, 1, 1, 2'b01, 16'h0700, 32'h99, 2'b01, 0, 1, 0, 0);
        exp_q.delete();
        RST = 1'b0;
        checkOutput("rst_valid", REC_VALID, 1'b0);
        checkOutput("rst_data", REC_DATA, 52'h0);
        checkOutput("rst_counts", {CNT_S1, CNT_S2, CNT_S3, CNT_ERR, CNT_SPLIT}, 20'h0);
        checkOutput("rst_flags", {OVF, STALL, SEL_FAULT}, 3'b000);
        idle(2, 1, 0);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_txn_monitor.md
Name: bus_txn_monitor

Overview:
- Passive observer directly downstream of the shared system bus that the arbiter drives.
- Consumes the arbitrated bus signals (HADDR, HWDATA, HRDATA, HRESP, HREADY, HMAS, SEL_1..3, MLOCK) plus a write tap, HWRITE.
- Captures every completed transfer into a show-ahead record FIFO.
- Keeps saturating per-slave and per-response counters and raises sticky fault flags for bus stalls and multi-select.
- Drives nothing onto the bus.

Parameters:
- DEPTH, 8, record FIFO entries; must be a power of two and at least 2.
- CNT_W, 16, width of every event counter.
- TIMEOUT, 16, consecutive wait-state cycles before STALL asserts; must be at least 1.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  synchronous reset, active-high.
- HADDR  in  16  arbitrated address; only bits [11:0] are recorded.
- HWDATA  in  32  arbitrated write data.
- HRDATA  in  32  muxed read data.
- HRESP  in  2  response code: 00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT.
- HREADY  in  1  transfer complete when 1.
- HMAS  in  2  id of the granted master.
- HWRITE  in  1  1 for a write transfer, 0 for a read.
- SEL_1, SEL_2, SEL_3  in  1 each  slave selects.
- MLOCK  in  1  locked transfer in progress.
- EN  in  1  capture enable; counters run regardless of EN.
- CLR  in  1  synchronous clear of counters and sticky flags.
- REC_POP  in  1  consumer pops the FIFO head.
- REC_VALID  out  1  FIFO not empty.
- REC_DATA  out  52  head record: {MLOCK, HMAS[1:0], slave[1:0], HWRITE, HRESP[1:0], HADDR[11:0], data[31:0]}.
- CNT_S1, CNT_S2, CNT_S3  out  CNT_W each  OKAY completions per slave.
- CNT_ERR  out  CNT_W  ERROR beats.
- CNT_SPLIT  out  CNT_W  SPLIT or RETRY beats.
- OVF  out  1  sticky: a record was dropped.
- STALL  out  1  sticky: wait-state timeout.
- SEL_FAULT  out  1  sticky: more than one SEL high.

Behaviour:
- Reset: RST synchronous, active-high. All outputs are 0, the FIFO is empty, and the stall counter is 0. Reset mid-transfer discards all state and ignores the bus on that edge.
- Beat: a rising edge where HREADY=1 and exactly one SEL_x is high.
- Slave field: SEL_1 -> 01, SEL_2 -> 10, SEL_3 -> 11.
- Data field: HWDATA when HWRITE=1, otherwise HRDATA.
- Counters, updated on every beat, in the cycle after the beat:
  - HRESP=00 increments CNT_Sx.
  - HRESP=01 increments CNT_ERR.
  - HRESP=10 or 11 increments CNT_SPLIT.
  - All counters saturate at 2^CNT_W-1 and do not wrap.
- FIFO:
  - A push occurs on a beat with EN=1.
  - The FIFO is show-ahead: REC_DATA and REC_VALID are registered. The first record appears the cycle after its beat (latency 1).
  - A pop occurs when REC_POP=1 and REC_VALID=1. A pop while empty is ignored.
  - Push while full without a simultaneous pop: the record is dropped and OVF sets.
  - Push and pop in the same cycle while full: both proceed and nothing is dropped.
  - Push and pop in the same cycle while holding 1 entry: REC_VALID stays 1.
  - Pointers are log2(DEPTH)+1 bits with a wrap bit; full and empty are derived from the pointers.
- Multi-select: two or more SEL high on an edge (whatever HREADY is) sets SEL_FAULT. That cycle produces no beat, no count and no push.
- Stall watchdog:
  - wcnt increments while any SEL is high and HREADY=0.
  - wcnt clears when HREADY=1 or no SEL is high.
  - When wcnt reaches TIMEOUT, STALL sets and wcnt holds at TIMEOUT.
  - A SPLIT response with HREADY=0 counts as wait cycles; the split slave is expected to release within TIMEOUT.
- CLR:
  - Zeroes all counters and OVF, STALL, SEL_FAULT.
  - Does not touch FIFO contents or pointers.
  - CLR and an event in the same cycle: CLR wins, so the counter reads 0 and the flag reads 0. The FIFO push still occurs.
- No combinational path from any input to any output.

Decomposition:
- Shared package bus_pkg holds:
  - HRESP codes RESP_OKAY=2'b00, RESP_ERROR=2'b01, RESP_RETRY=2'b10, RESP_SPLIT=2'b11.
  - Slave ids SLV_1=2'b01, SLV_2=2'b10, SLV_3=2'b11.
  - Record field offsets and REC_W=52.
- One sub-module, sync_fifo (parameters WIDTH, DEPTH; show-ahead, with full/empty), instantiated once.
- Beat decode, counters and watchdog stay in the top module.

Test Plan:
- Write beat: SEL_2=1, HREADY=1, HWRITE=1, HMAS=01, HADDR=0x0ABC, HWDATA=0xDEADBEEF, HRESP=00, EN=1 -> next cycle REC_VALID=1, REC_DATA={0,01,10,1,00,0xABC,0xDEADBEEF}, CNT_S2=1.
- Read with error: SEL_3=1, HWRITE=0, HRDATA=0x12345678, HRESP=01 -> record data=0x12345678, resp=01, CNT_ERR=1, CNT_S3=0.
- Overflow: 9 beats with no pop (DEPTH=8) -> OVF=1 after the 9th. Then 8 pops return beats 1..8 in order and REC_VALID falls after the 8th. Repeat with a pop in the same cycle as the 9th push -> OVF stays 0.
- Stall: SEL_1=1, HREADY=0 for 15 cycles -> STALL=0. On the 16th consecutive cycle -> STALL=1. Then HREADY=1 -> STALL stays 1. CLR -> STALL=0.
- Saturation and CLR: CNT_W=4, 17 OKAY beats to slave 1 -> CNT_S1=15. CLR asserted alongside an 18th beat -> CNT_S1=0 while the FIFO push still occurs.
- Fault and reset: SEL_1=SEL_3=1, HREADY=1 -> SEL_FAULT=1, no push, no count. RST with 3 records queued -> REC_VALID=0 and all outputs 0 on the next cycle.
